step_pulse_gen: RTL and testbench



---
 rtl/step_pulse_gen_pkg.sv | 30 +++
 rtl/step_pending_ctr.sv | 61 ++++++
 rtl/step_pulse_gen.sv | 127 ++++++++++++
 tb/tb_step_pulse_gen.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_pulse_gen_pkg.sv
// Shared configuration for the step/direction output stage and the move buffer.
package step_pulse_gen_pkg;

  // Pulse generator FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIR_SETUP = 2'd1,
    ST_HIGH      = 2'd2,
    ST_LOW       = 2'd3
  } pulse_state_e;

  // Width of the shared phase down-timer
  localparam int TIMER_BITS = 16;

  // Default timing at a 16 MHz system clock
  localparam int DEFAULT_DIR_SETUP_CYCLES  = 16;
  localparam int DEFAULT_PULSE_HIGH_CYCLES = 32;
  localparam int DEFAULT_PULSE_LOW_CYCLES  = 32;
  localparam int DEFAULT_PENDING_BITS      = 8;

  // Move buffer sizing used by the upstream move-execution logic
  localparam int MOVE_BUF_DEPTH     = 16;
  localparam int MOVE_BUF_ADDR_BITS = $clog2(MOVE_BUF_DEPTH);

  // A phase lasting N cycles loads N-1 and leaves when the timer reads zero
  function automatic logic [TIMER_BITS-1:0] timer_load(input int cycles);
    return TIMER_BITS'(cycles - 1);
  endfunction

endpackage

// File: rtl/step_pending_ctr.sv
// Signed count of requested-but-unemitted steps with saturation and a sticky drop flag.
module step_pending_ctr
  import step_pulse_gen_pkg::*;
#(
  parameter int PENDING_BITS = DEFAULT_PENDING_BITS
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           req_valid_i,
  input  logic                           req_dir_i,
  input  logic                           commit_valid_i,
  input  logic                           commit_dir_i,
  input  logic                           clear_overflow_i,
  output logic signed [PENDING_BITS-1:0] pending_o,
  output logic                           overflow_o
);

  localparam logic signed [PENDING_BITS-1:0] PEND_MAX = {1'b0, {(PENDING_BITS-1){1'b1}}};
  localparam logic signed [PENDING_BITS-1:0] PEND_MIN = {1'b1, {(PENDING_BITS-1){1'b0}}};
  localparam logic signed [PENDING_BITS-1:0] PEND_ONE = {{(PENDING_BITS-1){1'b0}}, 1'b1};

  logic signed [PENDING_BITS-1:0] pending_q, pending_d, after_commit;
  logic                           overflow_q, overflow_d, drop;

  // Commit first (always toward zero, so it cannot overflow), then apply or drop the request
  always_comb begin
    after_commit = pending_q;
    if (commit_valid_i) begin
      after_commit = commit_dir_i ? (pending_q - PEND_ONE) : (pending_q + PEND_ONE);
    end
    drop      = 1'b0;
    pending_d = after_commit;
    if (req_valid_i) begin
      if (req_dir_i) begin
        if (after_commit == PEND_MAX) drop = 1'b1;
        else                          pending_d = after_commit + PEND_ONE;
      end else begin
        if (after_commit == PEND_MIN) drop = 1'b1;
        else                          pending_d = after_commit - PEND_ONE;
      end
    end
    overflow_d = overflow_q;
    if (drop)                  overflow_d = 1'b1;
    else if (clear_overflow_i) overflow_d = 1'b0;
  end

  // Counter and sticky flag registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Converts single-cycle step requests into STEP/DIR pulses with setup, high and low timing.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int DIR_SETUP_CYCLES  = DEFAULT_DIR_SETUP_CYCLES,
  parameter int PULSE_HIGH_CYCLES = DEFAULT_PULSE_HIGH_CYCLES,
  parameter int PULSE_LOW_CYCLES  = DEFAULT_PULSE_LOW_CYCLES,
  parameter int PENDING_BITS      = DEFAULT_PENDING_BITS
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic                           step_req,
  input  logic                           dir_req,
  input  logic                           enable,
  input  logic                           clear_overflow,
  output logic                           step_out,
  output logic                           dir_out,
  output logic signed [PENDING_BITS-1:0] pending,
  output logic signed [31:0]             position,
  output logic                           busy,
  output logic                           overflow
);

  localparam logic [TIMER_BITS-1:0] SETUP_LOAD = timer_load(DIR_SETUP_CYCLES);
  localparam logic [TIMER_BITS-1:0] HIGH_LOAD  = timer_load(PULSE_HIGH_CYCLES);
  localparam logic [TIMER_BITS-1:0] LOW_LOAD   = timer_load(PULSE_LOW_CYCLES);

  pulse_state_e          state_q;
  logic [TIMER_BITS-1:0] timer_q;
  logic                  step_out_q, dir_out_q;
  logic signed [31:0]    position_q, position_d;
  logic                  pending_nz, pending_fwd, start_ok, commit;

  step_pending_ctr #(
    .PENDING_BITS(PENDING_BITS)
  ) u_pending (
    .clk_i           (CLK),
    .reset_i         (reset),
    .req_valid_i     (step_req),
    .req_dir_i       (dir_req),
    .commit_valid_i  (commit),
    .commit_dir_i    (dir_out_q),
    .clear_overflow_i(clear_overflow),
    .pending_o       (pending),
    .overflow_o      (overflow)
  );

  // A pulse may start only when enabled and DIR already points toward the pending steps;
  // the end of LOW chains straight into the next pulse so the step period is HIGH+LOW.
  always_comb begin
    pending_nz  = (pending != '0);
    pending_fwd = ~pending[PENDING_BITS-1];
    start_ok    = enable && pending_nz && (pending_fwd == dir_out_q);
    commit      = 1'b0;
    case (state_q)
      ST_IDLE:              commit = start_ok;
      ST_DIR_SETUP, ST_LOW: commit = (timer_q == '0) && start_ok;
      default:              commit = 1'b0;
    endcase
    position_d = dir_out_q ? (position_q + 32'sd1) : (position_q - 32'sd1);
  end

  // Pulse FSM with its down-timer, registered STEP/DIR outputs and position counter
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      step_out_q <= 1'b0;
      dir_out_q  <= 1'b0;
      position_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (commit) begin
            state_q    <= ST_HIGH;
            timer_q    <= HIGH_LOAD;
            step_out_q <= 1'b1;
            position_q <= position_d;
          end else if (enable && pending_nz) begin
            state_q   <= ST_DIR_SETUP;
            timer_q   <= SETUP_LOAD;
            dir_out_q <= pending_fwd;
          end
        end
        ST_DIR_SETUP: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else if (commit) begin
            state_q    <= ST_HIGH;
            timer_q    <= HIGH_LOAD;
            step_out_q <= 1'b1;
            position_q <= position_d;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HIGH: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else begin
            state_q    <= ST_LOW;
            timer_q    <= LOW_LOAD;
            step_out_q <= 1'b0;
          end
        end
        default: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - 1'b1;
          end else if (commit) begin
            state_q    <= ST_HIGH;
            timer_q    <= HIGH_LOAD;
            step_out_q <= 1'b1;
            position_q <= position_d;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign step_out = step_out_q;
  assign dir_out  = dir_out_q;
  assign position = position_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen: expected pulses are queued when requests are driven
// and checked against every observed STEP rising edge.
module tb_step_pulse_gen;

  localparam int DS = 4;
  localparam int HI = 3;
  localparam int LO = 2;
  localparam int PB = 4;

  logic                 CLK;
  logic                 reset;
  logic                 step_req;
  logic                 dir_req;
  logic                 enable;
  logic                 clear_overflow;
  logic                 step_out;
  logic                 dir_out;
  logic signed [PB-1:0] pending;
  logic signed [31:0]   position;
  logic                 busy;
  logic                 overflow;

  typedef struct {
    logic               dir;
    logic signed [31:0] pos;
    int                 riseCycle;
  } pulseExp_t;

  pulseExp_t expQ[$];
  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  logic prevStep  = 1'b0;
  logic haveFall  = 1'b0;
  int highCnt     = 0;
  int lowCnt      = 0;

  step_pulse_gen #(
    .DIR_SETUP_CYCLES (DS),
    .PULSE_HIGH_CYCLES(HI),
    .PULSE_LOW_CYCLES (LO),
    .PENDING_BITS     (PB)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .step_req      (step_req),
    .dir_req       (dir_req),
    .enable        (enable),
    .clear_overflow(clear_overflow),
    .step_out      (step_out),
    .dir_out       (dir_out),
    .pending       (pending),
    .position      (position),
    .busy          (busy),
    .overflow      (overflow)
  );

  // 10-time-unit clock and a free-running edge counter
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Pulse monitor: pops the scoreboard on every STEP rise and checks high and low widths
  always @(negedge CLK) begin
    pulseExp_t e;
    if (step_out === 1'b1 && !prevStep) begin
      if (haveFall) begin
        assertCount++;
        if (lowCnt < LO) begin
          failCount++;
          $display("[TB] FAIL low_time actual=%0d required>=%0d", lowCnt, LO);
        end
      end
      highCnt = 1;
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_pulse cycle=%0d dir=%0b pos=%0d", cyc, dir_out, position);
      end else begin
        e = expQ.pop_front();
        assertCount++;
        if (dir_out !== e.dir) begin
          failCount++;
          $display("[TB] FAIL pulse_dir actual=%0b required=%0b", dir_out, e.dir);
        end
        assertCount++;
        if (position !== e.pos) begin
          failCount++;
          $display("[TB] FAIL pulse_position actual=%0d required=%0d", position, e.pos);
        end
        assertCount++;
        if (cyc != e.riseCycle) begin
          failCount++;
          $display("[TB] FAIL pulse_rise_cycle actual=%0d required=%0d", cyc, e.riseCycle);
        end
      end
    end else if (step_out === 1'b1) begin
      highCnt++;
    end else if (prevStep) begin
      if (reset === 1'b1) begin
        haveFall = 1'b0;
      end else begin
        assertCount++;
        if (highCnt != HI) begin
          failCount++;
          $display("[TB] FAIL high_time actual=%0d required=%0d", highCnt, HI);
        end
        haveFall = 1'b1;
        lowCnt   = 1;
      end
    end else begin
      lowCnt++;
    end
    if (reset === 1'b1) haveFall = 1'b0;
    prevStep = (step_out === 1'b1);
  end

  // Hard stop in case a task loop never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic pushPulse(input logic d, input logic signed [31:0] p, input int c);
    pulseExp_t e;
    e.dir = d;
    e.pos = p;
    e.riseCycle = c;
    expQ.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1; step_req = 1'b0; dir_req = 1'b0; enable = 1'b1; clear_overflow = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    expQ.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while ((busy !== 1'b0 || pending !== '0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    assertCount++;
    if (n >= 300) begin
      failCount++;
      $display("[TB] FAIL %s_idle_timeout busy=%0b pending=%0d required idle", tag, busy, pending);
    end
    @(negedge CLK);
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL %s_missing_pulses actual=%0d required=0", tag, expQ.size());
    end
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic test_reset();
    reset = 1'b1; step_req = 1'b1; dir_req = 1'b1; enable = 1'b1; clear_overflow = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    assertCount++;
    if (step_out !== 1'b0) begin failCount++; $display("[TB] FAIL reset_step actual=%0b required=0", step_out); end
    assertCount++;
    if (dir_out !== 1'b0) begin failCount++; $display("[TB] FAIL reset_dir actual=%0b required=0", dir_out); end
    assertCount++;
    if (pending !== 4'sd0) begin failCount++; $display("[TB] FAIL reset_pending actual=%0d required=0", pending); end
    assertCount++;
    if (position !== 32'sd0) begin failCount++; $display("[TB] FAIL reset_position actual=%0d required=0", position); end
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy actual=%0b required=0", busy); end
    assertCount++;
    if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL reset_overflow actual=%0b required=0", overflow); end
    step_req = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_first_pulse();
    int k;
    do_reset();
    @(negedge CLK);
    step_req = 1'b1; dir_req = 1'b1; k = cyc + 1;
    pushPulse(1'b1, 32'sd1, k + 1 + DS);
    @(negedge CLK);
    step_req = 1'b0;
    assertCount++;
    if (pending !== 4'sd1) begin failCount++; $display("[TB] FAIL first_pending actual=%0d required=1", pending); end
    @(negedge CLK);
    assertCount++;
    if (dir_out !== 1'b1) begin failCount++; $display("[TB] FAIL first_dir_change actual=%0b required=1", dir_out); end
    assertCount++;
    if (step_out !== 1'b0) begin failCount++; $display("[TB] FAIL first_setup_step actual=%0b required=0", step_out); end
    wait_idle("first");
    assertCount++;
    if (position !== 32'sd1) begin failCount++; $display("[TB] FAIL first_position actual=%0d required=1", position); end
  endtask

  task automatic test_back_to_back();
    int k;
    do_reset();
    @(negedge CLK);
    step_req = 1'b1; dir_req = 1'b1; k = cyc + 1;
    pushPulse(1'b1, 32'sd1, k + 1 + DS);
    @(negedge CLK);
    step_req = 1'b0;
    wait_idle("b2b_prep");
    @(negedge CLK);
    step_req = 1'b1; dir_req = 1'b1; k = cyc + 1;
    pushPulse(1'b1, 32'sd2, k + 1);
    pushPulse(1'b1, 32'sd3, k + 1 + (HI + LO));
    pushPulse(1'b1, 32'sd4, k + 1 + 2 * (HI + LO));
    repeat (3) @(negedge CLK);
    step_req = 1'b0;
    wait_cycle(k + 2 * (HI + LO) + HI + LO);
    assertCount++;
    if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_busy_in_low actual=%0b required=1", busy); end
    @(negedge CLK);
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL b2b_busy_after actual=%0b required=0", busy); end
    assertCount++;
    if (position !== 32'sd4) begin failCount++; $display("[TB] FAIL b2b_position actual=%0d required=4", position); end
    wait_idle("b2b");
  endtask

  task automatic test_enable_gating();
    int k;
    do_reset();
    @(negedge CLK);
    enable = 1'b0; step_req = 1'b1; dir_req = 1'b1;
    @(negedge CLK);
    dir_req = 1'b1;
    @(negedge CLK);
    dir_req = 1'b0;
    @(negedge CLK);
    step_req = 1'b0;
    repeat (6) @(negedge CLK);
    assertCount++;
    if (pending !== 4'sd1) begin failCount++; $display("[TB] FAIL en_pending_held actual=%0d required=1", pending); end
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL en_busy_disabled actual=%0b required=0", busy); end
    enable = 1'b1; k = cyc + 1;
    pushPulse(1'b1, 32'sd1, k + DS);
    wait_idle("en");
    assertCount++;
    if (position !== 32'sd1) begin failCount++; $display("[TB] FAIL en_position actual=%0d required=1", position); end
  endtask

  task automatic test_overflow();
    do_reset();
    @(negedge CLK);
    enable = 1'b0; step_req = 1'b1; dir_req = 1'b1;
    repeat (7) @(negedge CLK);
    assertCount++;
    if (pending !== 4'sd7 || overflow !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL ovf_at_max actual=%0d/%0b required=7/0", pending, overflow);
    end
    @(negedge CLK);
    step_req = 1'b0;
    assertCount++;
    if (pending !== 4'sd7 || overflow !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL ovf_drop actual=%0d/%0b required=7/1", pending, overflow);
    end
    step_req = 1'b1; clear_overflow = 1'b1;
    @(negedge CLK);
    step_req = 1'b0; clear_overflow = 1'b0;
    assertCount++;
    if (overflow !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_drop_beats_clear actual=%0b required=1", overflow); end
    clear_overflow = 1'b1;
    @(negedge CLK);
    clear_overflow = 1'b0;
    assertCount++;
    if (overflow !== 1'b0 || pending !== 4'sd7) begin
      failCount++;
      $display("[TB] FAIL ovf_clear actual=%0b/%0d required=0/7", overflow, pending);
    end
    step_req = 1'b1; dir_req = 1'b0;
    repeat (7) @(negedge CLK);
    step_req = 1'b0;
    assertCount++;
    if (pending !== 4'sd0) begin failCount++; $display("[TB] FAIL ovf_cancel actual=%0d required=0", pending); end
    enable = 1'b1;
    repeat (10) @(negedge CLK);
    assertCount++;
    if (busy !== 1'b0 || position !== 32'sd0) begin
      failCount++;
      $display("[TB] FAIL ovf_no_pulse busy=%0b pos=%0d required 0/0", busy, position);
    end
  endtask

  task automatic test_reverse();
    int k;
    do_reset();
    @(negedge CLK);
    step_req = 1'b1; dir_req = 1'b1; k = cyc + 1;
    pushPulse(1'b1, 32'sd1, k + 1 + DS);
    @(negedge CLK);
    step_req = 1'b0;
    wait_idle("rev_prep");
    @(negedge CLK);
    step_req = 1'b1; dir_req = 1'b0; k = cyc + 1;
    pushPulse(1'b0, 32'sd0, k + 1 + DS);
    @(negedge CLK);
    step_req = 1'b0;
    @(negedge CLK);
    assertCount++;
    if (dir_out !== 1'b0) begin failCount++; $display("[TB] FAIL rev_dir_change actual=%0b required=0", dir_out); end
    wait_idle("rev");
    assertCount++;
    if (position !== 32'sd0) begin failCount++; $display("[TB] FAIL rev_position actual=%0d required=0", position); end
    @(negedge CLK);
    step_req = 1'b1; dir_req = 1'b0; k = cyc + 1;
    pushPulse(1'b0, -32'sd1, k + 1);
    @(negedge CLK);
    step_req = 1'b0;
    wait_idle("rev_wrap");
    assertCount++;
    if (position !== -32'sd1) begin failCount++; $display("[TB] FAIL rev_negative actual=%0d required=-1", position); end
  endtask

  task automatic test_reset_mid_pulse();
    int k;
    do_reset();
    @(negedge CLK);
    enable = 1'b0; step_req = 1'b1; dir_req = 1'b1;
    repeat (6) @(negedge CLK);
    step_req = 1'b0; enable = 1'b1; k = cyc + 1;
    pushPulse(1'b1, 32'sd1, k + DS);
    wait_cycle(k + DS);
    assertCount++;
    if (step_out !== 1'b1 || pending !== 4'sd5) begin
      failCount++;
      $display("[TB] FAIL mid_pre_reset step=%0b pending=%0d required 1/5", step_out, pending);
    end
    reset = 1'b1;
    @(negedge CLK);
    assertCount++;
    if (step_out !== 1'b0 || pending !== 4'sd0 || position !== 32'sd0 || busy !== 1'b0 || dir_out !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL mid_reset step=%0b pend=%0d pos=%0d busy=%0b dir=%0b required all 0",
               step_out, pending, position, busy, dir_out);
    end
    @(negedge CLK);
    reset = 1'b0;
    assertCount++;
    if (expQ.size() != 0) begin failCount++; $display("[TB] FAIL mid_missing_pulse actual=%0d required=0", expQ.size()); end
    repeat (5) @(negedge CLK);
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL mid_after_idle actual=%0b required=0", busy); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_first_pulse();
    test_back_to_back();
    test_enable_gating();
    test_overflow();
    test_reverse();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
